// File: rtl/csi2_depacketizer.sv
// CSI-2 packet parser: turns the receiver's 16-bit word stream into frame/line
// sync pulses and a payload word stream for a single virtual channel.
module csi2_depacketizer #(
  parameter logic [1:0]  VC_SEL    = 2'd0,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sol,
  output logic        out_eol,
  output logic [5:0]  out_dt,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] frame_num,
  output logic [15:0] line_count,
  output logic        err_len,
  output logic        err_trunc
);

  localparam logic [16:0] MAX_WC = 17'(2 * MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_PAYLOAD, S_CSUM, S_DROP} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_di, w_di_next;
  logic [7:0]  r_wc_lo, w_wc_lo_next;
  logic [15:0] r_rem, w_rem_next;
  logic        r_first, w_first_next;
  logic [15:0] r_lines, w_lines_next;

  logic [15:0] w_out_data;
  logic        w_out_valid, w_out_sol, w_out_eol;
  logic [5:0]  w_out_dt;
  logic        w_frame_start, w_frame_end, w_err_len, w_err_trunc;
  logic [15:0] w_frame_num, w_line_count;

  logic [15:0] w_wc;
  logic [1:0]  w_vc;
  logic [5:0]  w_dt;

  assign w_wc = {in_data[7:0], r_wc_lo};
  assign w_vc = r_di[7:6];
  assign w_dt = r_di[5:0];

  always_comb begin
    w_state_next  = r_state;
    w_di_next     = r_di;
    w_wc_lo_next  = r_wc_lo;
    w_rem_next    = r_rem;
    w_first_next  = r_first;
    w_lines_next  = r_lines;
    w_out_data    = out_data;
    w_out_valid   = 1'b0;
    w_out_sol     = 1'b0;
    w_out_eol     = 1'b0;
    w_out_dt      = out_dt;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_frame_num   = frame_num;
    w_line_count  = line_count;
    w_err_len     = 1'b0;
    w_err_trunc   = 1'b0;

    if (in_valid) begin
      // A start-of-packet always wins: whatever was in flight is abandoned.
      if (in_sop && r_state != S_IDLE) begin
        w_err_trunc  = (r_state != S_DROP);
        w_di_next    = in_data[7:0];
        w_wc_lo_next = in_data[15:8];
        w_state_next = S_HDR1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_sop) begin
              w_di_next    = in_data[7:0];
              w_wc_lo_next = in_data[15:8];
              w_state_next = S_HDR1;
            end
          end
          S_HDR1: begin
            if (w_vc != VC_SEL) begin
              w_state_next = S_DROP;
            end else if (w_dt < 6'h10) begin
              w_state_next = S_IDLE;
              if (w_dt == 6'h00) begin
                w_frame_start = 1'b1;
                w_frame_num   = w_wc;
                w_lines_next  = 16'd0;
              end else if (w_dt == 6'h01) begin
                w_frame_end  = 1'b1;
                w_line_count = r_lines;
              end
            end else if (w_wc[0] || ({1'b0, w_wc} > MAX_WC)) begin
              w_err_len    = 1'b1;
              w_state_next = S_DROP;
            end else if (w_wc == 16'd0) begin
              w_state_next = S_CSUM;
            end else begin
              w_rem_next   = {1'b0, w_wc[15:1]};
              w_first_next = 1'b1;
              w_out_dt     = w_dt;
              w_state_next = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            w_out_valid  = 1'b1;
            w_out_data   = in_data;
            w_out_sol    = r_first;
            w_out_eol    = (r_rem == 16'd1);
            w_first_next = 1'b0;
            w_rem_next   = r_rem - 16'd1;
            if (r_rem == 16'd1) begin
              w_state_next = S_CSUM;
              if (r_lines != 16'hFFFF) w_lines_next = r_lines + 16'd1;
            end
          end
          S_CSUM:  w_state_next = S_IDLE;
          S_DROP:  w_state_next = S_DROP;
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_di        <= '0;
      r_wc_lo     <= '0;
      r_rem       <= '0;
      r_first     <= 1'b0;
      r_lines     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sol     <= 1'b0;
      out_eol     <= 1'b0;
      out_dt      <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_num   <= '0;
      line_count  <= '0;
      err_len     <= 1'b0;
      err_trunc   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_di        <= w_di_next;
      r_wc_lo     <= w_wc_lo_next;
      r_rem       <= w_rem_next;
      r_first     <= w_first_next;
      r_lines     <= w_lines_next;
      out_data    <= w_out_data;
      out_valid   <= w_out_valid;
      out_sol     <= w_out_sol;
      out_eol     <= w_out_eol;
      out_dt      <= w_out_dt;
      frame_start <= w_frame_start;
      frame_end   <= w_frame_end;
      frame_num   <= w_frame_num;
      line_count  <= w_line_count;
      err_len     <= w_err_len;
      err_trunc   <= w_err_trunc;
    end
  end

endmodule

// File: tb/tb_csi2_depacketizer.sv
// Bench for csi2_depacketizer: packet-level model predicts every output event
// and the cycle it must appear on; a per-cycle compare process checks the DUT.
module tb_csi2_depacketizer;

  localparam logic [1:0] VSEL = 2'd0;
  localparam int         MAXW = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic [15:0] out_data;
  logic        out_valid, out_sol, out_eol;
  logic [5:0]  out_dt;
  logic        frame_start, frame_end;
  logic [15:0] frame_num, line_count;
  logic        err_len, err_trunc;

  csi2_depacketizer #(.VC_SEL(VSEL), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .out_data(out_data), .out_valid(out_valid), .out_sol(out_sol), .out_eol(out_eol),
    .out_dt(out_dt), .frame_start(frame_start), .frame_end(frame_end),
    .frame_num(frame_num), .line_count(line_count), .err_len(err_len), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        v, sol, eol, fs, fe, el, et;
    logic [15:0] data, fnum, lcnt;
    logic [5:0]  dt;
  } ev_t;

  ev_t         q[$];
  logic [15:0] cap_d[$];
  logic [1:0]  cap_f[$];
  logic [15:0] ref_d[$];
  int          cyc = 0;
  int          checks = 0;
  int          errs = 0;
  logic        gaps = 1'b0;
  logic        m_open = 1'b0;
  logic [15:0] m_lines = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t blank();
    ev_t e;
    e.cyc = cyc + 1;
    e.v = 0; e.sol = 0; e.eol = 0; e.fs = 0; e.fe = 0; e.el = 0; e.et = 0;
    e.data = 0; e.fnum = 0; e.lcnt = 0; e.dt = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic sop);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_sop   = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
    end
  endtask

  task automatic header(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    ev_t e;
    drive({wc[7:0], vc, dt}, 1'b1);
    if (m_open) begin
      e = blank(); e.et = 1; q.push_back(e);
      m_open = 0;
    end
    drive({8'hA5, wc[15:8]}, 1'b0);
  endtask

  task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    ev_t e;
    header(vc, dt, wc);
    if (vc == VSEL && dt == 6'h00) begin
      e = blank(); e.fs = 1; e.fnum = wc; q.push_back(e);
      m_lines = 0;
    end else if (vc == VSEL && dt == 6'h01) begin
      e = blank(); e.fe = 1; e.lcnt = m_lines; q.push_back(e);
    end
  endtask

  // keep = number of payload words actually sent; fewer than WC/2 leaves it open.
  task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [15:0] base, input int keep);
    ev_t e;
    int n, nsend;
    logic bad, live;
    n     = int'(wc >> 1);
    bad   = wc[0] || (int'(wc) > 2 * MAXW);
    live  = (vc == VSEL) && !bad;
    nsend = bad ? 3 : ((keep < n) ? keep : n);
    header(vc, dt, wc);
    if (vc == VSEL && bad) begin
      e = blank(); e.el = 1; q.push_back(e);
    end
    for (int i = 0; i < nsend; i++) begin
      drive(base + 16'(i) * 16'h1111, 1'b0);
      if (live) begin
        e = blank(); e.v = 1; e.data = base + 16'(i) * 16'h1111;
        e.sol = (i == 0); e.eol = (i == n - 1); e.dt = dt;
        q.push_back(e);
      end
    end
    if (!bad && nsend == n) begin
      drive(16'hCCCC, 1'b0);
      if (live && n > 0 && m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
    end else begin
      m_open = live;
    end
  endtask

  always @(negedge clk) begin
    ev_t  e;
    logic act, hit, ok;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errs++;
      $display("FAIL missing_event cyc=%0d required_at=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    act = out_valid | frame_start | frame_end | err_len | err_trunc;
    hit = (q.size() > 0) && (q[0].cyc == cyc);
    if (act || hit) begin
      checks++;
      if (!hit) begin
        errs++;
        $display("FAIL unexpected_output cyc=%0d got v=%b fs=%b fe=%b el=%b et=%b data=%h required no output",
                 cyc, out_valid, frame_start, frame_end, err_len, err_trunc, out_data);
      end else begin
        e  = q.pop_front();
        ok = (out_valid == e.v) && (frame_start == e.fs) && (frame_end == e.fe) &&
             (err_len == e.el) && (err_trunc == e.et);
        if (e.v)  ok = ok && (out_data == e.data) && (out_sol == e.sol) &&
                       (out_eol == e.eol) && (out_dt == e.dt);
        if (e.fs) ok = ok && (frame_num == e.fnum);
        if (e.fe) ok = ok && (line_count == e.lcnt);
        if (!ok) begin
          errs++;
          $display("FAIL stream_cmp cyc=%0d got v=%b d=%h sol=%b eol=%b dt=%h fs=%b fn=%h fe=%b lc=%h el=%b et=%b required v=%b d=%h sol=%b eol=%b dt=%h fs=%b fn=%h fe=%b lc=%h el=%b et=%b",
                   cyc, out_valid, out_data, out_sol, out_eol, out_dt, frame_start, frame_num,
                   frame_end, line_count, err_len, err_trunc,
                   e.v, e.data, e.sol, e.eol, e.dt, e.fs, e.fnum, e.fe, e.lcnt, e.el, e.et);
        end
      end
    end
    if (out_valid) begin
      cap_d.push_back(out_data);
      cap_f.push_back({out_sol, out_eol});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_pulses", 32'({out_sol, out_eol, frame_start, frame_end, err_len, err_trunc}), 0);
    chk("reset_out_dt", 32'(out_dt), 0);
    chk("reset_frame_num", 32'(frame_num), 0);
    chk("reset_line_count", 32'(line_count), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Non-sop words in IDLE are ignored.
    drive(16'hBEEF, 1'b0); drive(16'h1234, 1'b0); idle(1);

    // Basic frame.
    cap_d.delete(); cap_f.delete();
    send_short(2'd0, 6'h00, 16'h0005);
    send_long(2'd0, 6'h2B, 16'd8, 16'h1111, 99);
    send_short(2'd0, 6'h01, 16'h0000);
    idle(2);
    chk("fs_frame_num", 32'(frame_num), 32'h5);
    chk("fe_line_count", 32'(line_count), 1);
    chk("long_out_dt", 32'(out_dt), 32'h2B);
    chk("long_word_count", cap_d.size(), 4);
    if (cap_d.size() == 4) begin
      chk("long_first_word", 32'(cap_d[0]), 32'h1111);
      chk("long_first_flags", 32'(cap_f[0]), 32'b10);
      chk("long_last_word", 32'(cap_d[3]), 32'h4444);
      chk("long_last_flags", 32'(cap_f[3]), 32'b01);
    end
    ref_d = cap_d;

    // Foreign virtual channel.
    cap_d.delete(); cap_f.delete();
    send_long(2'd1, 6'h2B, 16'd8, 16'h1111, 99);
    send_short(2'd0, 6'h01, 16'h0000);
    idle(2);
    chk("vc_drop_words", cap_d.size(), 0);
    chk("vc_drop_line_count", 32'(line_count), 1);

    // Illegal lengths, then clean resume.
    send_long(2'd0, 6'h2B, 16'd7, 16'h2000, 99);
    send_short(2'd0, 6'h00, 16'h0009);
    send_long(2'd0, 6'h2B, 16'(2 * MAXW + 2), 16'h3000, 99);
    send_long(2'd0, 6'h2A, 16'd4, 16'h0101, 99);
    idle(2);
    chk("resume_frame_num", 32'(frame_num), 32'h9);
    chk("resume_out_dt", 32'(out_dt), 32'h2A);

    // Truncation, then a single-word payload.
    cap_d.delete(); cap_f.delete();
    send_long(2'd0, 6'h2B, 16'd16, 16'h1000, 3);
    send_long(2'd0, 6'h2C, 16'd2, 16'h5A5A, 99);
    send_short(2'd0, 6'h01, 16'h0000);
    idle(2);
    chk("trunc_word_count", cap_d.size(), 4);
    if (cap_d.size() == 4) begin
      chk("single_word", 32'(cap_d[3]), 32'h5A5A);
      chk("single_flags", 32'(cap_f[3]), 32'b11);
    end
    chk("trunc_line_count", 32'(line_count), 2);

    // Same frame with random input gaps.
    cap_d.delete(); cap_f.delete();
    gaps = 1'b1;
    send_short(2'd0, 6'h00, 16'h0005);
    send_long(2'd0, 6'h2B, 16'd8, 16'h1111, 99);
    send_short(2'd0, 6'h01, 16'h0000);
    gaps = 1'b0;
    idle(3);
    chk("gap_word_count", cap_d.size(), ref_d.size());
    for (int i = 0; i < 4; i++)
      if (i < cap_d.size() && i < ref_d.size())
        chk("gap_word_match", 32'(cap_d[i]), 32'(ref_d[i]));

    // Reset in the middle of a payload.
    send_long(2'd0, 6'h2D, 16'd8, 16'h7000, 2);
    idle(1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_dt", 32'(out_dt), 0);
    chk("midrst_frame_num", 32'(frame_num), 0);
    chk("midrst_line_count", 32'(line_count), 0);
    q.delete(); m_open = 1'b0; m_lines = 16'd0;
    @(posedge clk); #1 reset = 1'b0;
    drive(16'hC0DE, 1'b0);
    idle(1);
    send_short(2'd0, 6'h00, 16'h0003);
    send_long(2'd0, 6'h2B, 16'd2, 16'h0F0F, 99);
    send_short(2'd0, 6'h01, 16'h0000);
    idle(3);
    chk("postrst_line_count", 32'(line_count), 1);
    chk("postrst_frame_num", 32'(frame_num), 32'h3);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/csi2_depacketizer.md
# csi2_depacketizer

Packet parser sitting directly downstream of the MIPI CSI-2 receiver front end in the dashcam video path. Consumes the receiver's 16-bit word stream and decodes CSI-2 packet headers: short packets become frame/line sync pulses, and long-packet payload becomes a pixel-word stream. It drops packets from foreign virtual channels, rejects illegal lengths, counts lines per frame and flags truncated packets for the downstream pixel unpacker.

## Interface
Parameters:
- VC_SEL, 2'd0: the only virtual channel forwarded; packets with any other DI[7:6] are dropped silently.
- MAX_WORDS, 2048: largest accepted long-packet payload, in 16-bit words (WC ≤ 2*MAX_WORDS bytes).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- in_data  in  16  word from the receiver; byte 0 is in [7:0].
- in_valid  in  1  in_data is valid this cycle; gaps are allowed anywhere.
- in_sop  in  1  qualified by in_valid; marks the first header word of a packet.
- out_data  out  16  payload word.
- out_valid  out  1  out_data is valid.
- out_sol  out  1  with out_valid; first payload word of a long packet.
- out_eol  out  1  with out_valid; last payload word of a long packet.
- out_dt  out  6  data type of the packet currently streaming; held between packets.
- frame_start  out  1  one-cycle pulse on a Frame Start short packet.
- frame_end  out  1  one-cycle pulse on a Frame End short packet.
- frame_num  out  16  WC field of the last Frame Start packet.
- line_count  out  16  number of long packets with out_eol in the frame just ended; updated with frame_end.
- err_len  out  1  one-cycle pulse: odd WC, or WC > 2*MAX_WORDS.
- err_trunc  out  1  one-cycle pulse: in_sop arrived before a packet completed.

## Operation
- Header layout, 2 words:
  - word0 = {WC[7:0], DI}.
  - word1 = {ECC, WC[15:8]}.
  - DI = {VC[1:0], DT[5:0]}.
  - ECC is consumed but not checked.
- FSM states: IDLE, HDR1, PAYLOAD, CSUM, DROP.
- IDLE: a valid word with in_sop latches DI and WC[7:0], then goes to HDR1. Valid words without in_sop are ignored.
- HDR1: the next valid word completes WC.
  - VC ≠ VC_SEL: go to DROP.
  - DT < 0x10 (short packet): act, then go to IDLE.
    - DT 0x00: pulse frame_start, frame_num ← WC, clear the internal line counter.
    - DT 0x01: pulse frame_end, line_count ← internal counter.
    - Any other short DT: ignored.
  - DT ≥ 0x10 (long packet):
    - WC odd or WC > 2*MAX_WORDS: pulse err_len, go to DROP.
    - WC = 0: go to CSUM.
    - Otherwise: load the remaining-word counter with WC/2, go to PAYLOAD, and set out_dt ← DT.
- PAYLOAD: each valid word is forwarded.
  - out_sol is asserted on the first word.
  - out_eol is asserted when the remaining count is 1.
  - After the last word, go to CSUM and increment the internal line counter (saturates at 0xFFFF).
- CSUM: one valid word (checksum) is discarded, then go to IDLE. The checksum is not checked.
- DROP: discard words until the next in_sop.
- in_sop in any state other than IDLE:
  - The current packet is abandoned and that word is taken as a new word0 (go to HDR1).
  - err_trunc pulses if the state was HDR1, PAYLOAD or CSUM. It does not pulse from DROP.
  - No out_eol is generated and the line counter is not incremented.
- frame_end with no preceding frame_start: line_count reports the count accumulated since reset or since the last Frame Start.

## Timing
- All outputs are registered.
- out_* and all pulses appear exactly 1 cycle after the input word that causes them.
- Throughput: one word per cycle, no backpressure.
- Input gaps (in_valid low) produce out_valid low. They never change state.
- Reset values:
  - All outputs 0.
  - out_dt = 0, frame_num = 0, line_count = 0.
  - FSM = IDLE, all counters 0.
- Reset mid-packet: everything returns to the reset values on the next edge. No err pulses are generated by the reset itself.
- A single-word payload (WC = 2) asserts out_sol and out_eol on the same cycle.
- err_len and err_trunc never coincide with out_valid from the same input word.

## Test plan
- Frame Start (DI 0x00, WC 0x0005), a long packet DT 0x2B WC 8 with words 0x1111..0x4444 plus checksum, then Frame End:
  - frame_start pulses and frame_num = 5.
  - Four out_valid words, with out_sol on 0x1111 and out_eol on 0x4444, out_dt = 0x2B.
  - frame_end pulses with line_count = 1.
- Same long packet on VC 1 with VC_SEL = 0: no out_valid, no error pulses, and line_count unchanged at the next Frame End.
- Long packet with WC = 7: err_len pulses, no out_valid, and the block resumes cleanly on the next in_sop. Repeat with WC = 2*MAX_WORDS + 2.
- Long packet WC 16 with in_sop arriving after 3 payload words: err_trunc pulses, no out_eol, and a following WC 2 packet yields one word with out_sol = out_eol = 1.
- Random in_valid gaps inside header, payload and checksum: output words are identical to the gap-free run. Then assert reset mid-payload: all outputs are 0 the next cycle and the FSM is IDLE.
